// File: rtl/eq_seq_ctrl.sv
// eq_seq_ctrl: sequential wide-operand equality controller.
// The operands are captured on an accepted start. They are then compared LSB-first,
// 2 bits per cycle, through a single 2-bit equality slice. The walk stops at the
// first mismatching slice, and the block reports the equal/not-equal result
// together with the index of that slice.

// eq2: 2-bit equality slice; the only equality logic used by the controller.
module eq2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       e
);
  assign e = (x == y);
endmodule

module eq_seq_ctrl #(
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done,
  output logic          aeqb,
  output logic [IW-1:0] mism_idx
);

  localparam int S = W / 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic [IW-1:0] idx;
  logic [1:0]    slice_a;
  logic [1:0]    slice_b;
  logic          e;

  // Handshake outputs are decoded directly from the state register.
  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // Select the slice addressed by idx from each stored operand.
  always_comb begin
    // NOTE: defaults written first keep this block purely combinational (no latch).
    slice_a = 2'b00;
    slice_b = 2'b00;
    for (int j = 0; j < S; j++) begin
      if (idx == IW'(j)) begin
        slice_a = ra[2*j +: 2];
        slice_b = rb[2*j +: 2];
      end
    end
  end

  eq2 u_eq2 (
    .x (slice_a),
    .y (slice_b),
    .e (e)
  );

  // Control FSM with the operand copies, the slice counter and the registered result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      idx      <= '0;
      aeqb     <= 1'b0;
      mism_idx <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            idx   <= '0;
            state <= CMP;
          end
        end
        CMP: begin
          if (!e) begin
            aeqb     <= 1'b0;
            mism_idx <= idx;
            state    <= DONE;
          end else if (idx == LAST_IDX) begin
            aeqb     <= 1'b1;
            mism_idx <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        // NOTE: the unused encoding recovers to IDLE instead of locking up.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// tb_eq_seq_ctrl: directed self-checking bench for eq_seq_ctrl.
// It exercises a W=8 instance and a W=2 instance.
module tb_eq_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       ready8, done8, aeqb8;
  logic [1:0] mism8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       ready2, done2, aeqb2;
  logic [0:0] mism2;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  eq_seq_ctrl #(.W(8), .IW(2)) u_dut8 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start8),
    .a        (a8),
    .b        (b8),
    .ready    (ready8),
    .done     (done8),
    .aeqb     (aeqb8),
    .mism_idx (mism8)
  );

  eq_seq_ctrl #(.W(2), .IW(1)) u_dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start2),
    .a        (a2),
    .b        (b2),
    .ready    (ready2),
    .done     (done2),
    .aeqb     (aeqb2),
    .mism_idx (mism2)
  );

  // Wait (bounded) for ready, then present operands with a 1-cycle start on the W=8 DUT.
  task automatic go8(input logic [7:0] av, input logic [7:0] bv);
    int k;
    k = 0;
    while (!ready8 && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) begin
      n_cmp++; n_mis++;
      $display("FAIL go8_ready: ready stayed %0b, expected 1 within 20 edges", ready8);
    end
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Count the edges after the accepting edge until done is seen (bounded at 20).
  task automatic wait_done8(output int edges);
    edges = 0;
    while (!done8 && edges < 20) begin @(posedge clk); #1; edges++; end
  endtask

  task automatic go2(input logic [1:0] av, input logic [1:0] bv);
    int k;
    k = 0;
    while (!ready2 && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) begin
      n_cmp++; n_mis++;
      $display("FAIL go2_ready: ready stayed %0b, expected 1 within 20 edges", ready2);
    end
    a2 = av; b2 = bv; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic wait_done2(output int edges);
    edges = 0;
    while (!done2 && edges < 20) begin @(posedge clk); #1; edges++; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    n_cmp++; if (ready8 !== 1'b1) begin n_mis++; $display("FAIL rst_ready8: got %b expected 1", ready8); end
    n_cmp++; if (done8 !== 1'b0) begin n_mis++; $display("FAIL rst_done8: got %b expected 0", done8); end
    n_cmp++; if (aeqb8 !== 1'b0) begin n_mis++; $display("FAIL rst_aeqb8: got %b expected 0", aeqb8); end
    n_cmp++; if (mism8 !== 2'd0) begin n_mis++; $display("FAIL rst_mism8: got %0d expected 0", mism8); end
    n_cmp++; if (ready2 !== 1'b1 || done2 !== 1'b0) begin
      n_mis++; $display("FAIL rst_w2: got ready=%b done=%b expected ready=1 done=0", ready2, done2);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_match;
    int ed;
    go8(8'hA5, 8'hA5);
    n_cmp++; if (ready8 !== 1'b0) begin n_mis++; $display("FAIL match_busy: ready got %b expected 0", ready8); end
    wait_done8(ed);
    n_cmp++; if (ed != 4) begin n_mis++; $display("FAIL match_latency: done after E%0d expected E4", ed); end
    n_cmp++; if (aeqb8 !== 1'b1) begin n_mis++; $display("FAIL match_aeqb: got %b expected 1", aeqb8); end
    n_cmp++; if (mism8 !== 2'd0) begin n_mis++; $display("FAIL match_idx: got %0d expected 0", mism8); end
    @(posedge clk); #1;
    n_cmp++; if (done8 !== 1'b0) begin n_mis++; $display("FAIL match_pulse: done got %b expected 0", done8); end
    n_cmp++; if (ready8 !== 1'b1) begin n_mis++; $display("FAIL match_idle: ready got %b expected 1", ready8); end
  endtask

  task automatic test_mismatch;
    int ed;
    go8(8'h01, 8'h00);
    wait_done8(ed);
    n_cmp++; if (ed != 1) begin n_mis++; $display("FAIL mis0_latency: done after E%0d expected E1", ed); end
    n_cmp++; if (aeqb8 !== 1'b0) begin n_mis++; $display("FAIL mis0_aeqb: got %b expected 0", aeqb8); end
    n_cmp++; if (mism8 !== 2'd0) begin n_mis++; $display("FAIL mis0_idx: got %0d expected 0", mism8); end
    go8(8'h80, 8'h00);
    wait_done8(ed);
    n_cmp++; if (ed != 4) begin n_mis++; $display("FAIL mis3_latency: done after E%0d expected E4", ed); end
    n_cmp++; if (aeqb8 !== 1'b0) begin n_mis++; $display("FAIL mis3_aeqb: got %b expected 0", aeqb8); end
    n_cmp++; if (mism8 !== 2'd3) begin n_mis++; $display("FAIL mis3_idx: got %0d expected 3", mism8); end
    @(posedge clk); #1;
    n_cmp++; if (ready8 !== 1'b1 || mism8 !== 2'd3) begin
      n_mis++; $display("FAIL mis3_hold: got ready=%b idx=%0d expected ready=1 idx=3", ready8, mism8);
    end
  endtask

  task automatic test_ignored_start;
    int pulses, first;
    logic res;
    pulses = 0; first = -1; res = 1'bx;
    go8(8'h3C, 8'h3C);
    a8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int e = 2; e <= 12; e++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        if (first < 0) first = e;
        res = aeqb8;
      end
    end
    n_cmp++; if (pulses != 1) begin n_mis++; $display("FAIL ign_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (first != 4) begin n_mis++; $display("FAIL ign_latency: done after E%0d expected E4", first); end
    n_cmp++; if (res !== 1'b1) begin n_mis++; $display("FAIL ign_aeqb: got %b expected 1", res); end
  endtask

  task automatic test_back_to_back;
    int exp_e[4] = '{4, 9, 15, 20};
    logic exp_a[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_m[4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    int de[4];
    logic da[4];
    logic [1:0] dm[4];
    int nd, consec;
    logic prev;
    nd = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 4; i++) begin de[i] = -1; da[i] = 1'bx; dm[i] = 2'bxx; end
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (prev) consec++;
        if (nd < 4) begin de[nd] = e; da[nd] = aeqb8; dm[nd] = mism8; end
        nd++;
        a8 = (a8 == 8'h00) ? 8'h10 : 8'h00;
        if (nd == 4) start8 = 1'b0;
      end
      prev = done8;
    end
    start8 = 1'b0;
    n_cmp++; if (nd != 4) begin n_mis++; $display("FAIL b2b_count: got %0d pulses expected 4", nd); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (de[i] != exp_e[i]) begin n_mis++; $display("FAIL b2b_edge%0d: got E%0d expected E%0d", i, de[i], exp_e[i]); end
      n_cmp++; if (da[i] !== exp_a[i]) begin n_mis++; $display("FAIL b2b_aeqb%0d: got %b expected %b", i, da[i], exp_a[i]); end
      n_cmp++; if (dm[i] !== exp_m[i]) begin n_mis++; $display("FAIL b2b_idx%0d: got %0d expected %0d", i, dm[i], exp_m[i]); end
    end
    n_cmp++; if (consec != 0) begin n_mis++; $display("FAIL b2b_consec: got %0d back-to-back done cycles expected 0", consec); end
  endtask

  task automatic test_async_reset;
    int pulses, ed;
    pulses = 0;
    go8(8'h00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ready8 !== 1'b1) begin n_mis++; $display("FAIL arst_ready: got %b expected 1", ready8); end
    n_cmp++; if (done8 !== 1'b0) begin n_mis++; $display("FAIL arst_done: got %b expected 0", done8); end
    n_cmp++; if (aeqb8 !== 1'b0) begin n_mis++; $display("FAIL arst_aeqb: got %b expected 0", aeqb8); end
    n_cmp++; if (mism8 !== 2'd0) begin n_mis++; $display("FAIL arst_idx: got %0d expected 0", mism8); end
    @(negedge clk); reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_mis++; $display("FAIL arst_nodone: got %0d pulses expected 0", pulses); end
    go8(8'hFF, 8'hFF);
    wait_done8(ed);
    n_cmp++; if (ed != 4) begin n_mis++; $display("FAIL arst_latency: done after E%0d expected E4", ed); end
    n_cmp++; if (aeqb8 !== 1'b1) begin n_mis++; $display("FAIL arst_aeqb_after: got %b expected 1", aeqb8); end
  endtask

  task automatic test_w2;
    int ed;
    go2(2'b10, 2'b10);
    wait_done2(ed);
    n_cmp++; if (ed != 1) begin n_mis++; $display("FAIL w2_match_latency: done after E%0d expected E1", ed); end
    n_cmp++; if (aeqb2 !== 1'b1) begin n_mis++; $display("FAIL w2_match_aeqb: got %b expected 1", aeqb2); end
    go2(2'b10, 2'b11);
    wait_done2(ed);
    n_cmp++; if (ed != 1) begin n_mis++; $display("FAIL w2_mis_latency: done after E%0d expected E1", ed); end
    n_cmp++; if (aeqb2 !== 1'b0) begin n_mis++; $display("FAIL w2_mis_aeqb: got %b expected 0", aeqb2); end
    n_cmp++; if (mism2 !== 1'b0) begin n_mis++; $display("FAIL w2_mis_idx: got %0d expected 0", mism2); end
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_mismatch();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    test_w2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eq_seq_ctrl.md
# eq_seq_ctrl

Sequential wide-operand equality controller. It captures two W-bit operands on a start handshake and walks them LSB-first, 2 bits per cycle, through one internal `eq2` 2-bit equality slice. It stops at the first mismatching slice and reports the equal/not-equal result together with the index of the failing slice. The block lets one small comparator serve operands of any even width, at a cost of one cycle per slice.

## Interface
Parameters:
- `W`, default 8: operand width; must be even and ≥ 2. Number of slices is S = W/2.
- `IW`, default 2: width of the slice-index output; must satisfy 2^IW ≥ S and IW ≥ 1.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a compare; accepted only on an edge where `ready`=1.
- `a`  in  W  — operand A; sampled only on the accepting edge.
- `b`  in  W  — operand B; sampled only on the accepting edge.
- `ready`  out  1  — 1 only in the IDLE state; decoded from the state register.
- `done`  out  1  — 1-cycle pulse; 1 only in the DONE state.
- `aeqb`  out  1  — registered result: 1 = all W bits equal.
- `mism_idx`  out  IW  — registered index of the first mismatching slice; 0 when `aeqb`=1.

## Operation
- Storage:
  - `ra`, `rb`: W-bit operand copies.
  - `idx`: IW-bit slice counter.
  - A 2-bit state register holding IDLE, CMP or DONE.
- Slice j covers bits [2j+1:2j]. The current slice `ra/rb[2*idx+1:2*idx]` feeds one `eq2` instance. Its output `e` is the only equality logic in the block.
- IDLE:
  - `ready`=1.
  - On `start`=1: `ra`<=`a`, `rb`<=`b`, `idx`<=0, go to CMP.
  - Otherwise stay in IDLE.
- CMP:
  - `e`=0: `aeqb`<=0, `mism_idx`<=`idx`, go to DONE.
  - `e`=1 and `idx`=S-1: `aeqb`<=1, `mism_idx`<=0, go to DONE.
  - Otherwise: `idx`<=`idx`+1, stay in CMP.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Changes on `a`/`b` after the accepting edge have no effect.
- `aeqb`/`mism_idx` change only on the CMP->DONE edge. They hold their values through IDLE until the next result is written.
- The counter never wraps: CMP always exits at `idx`=S-1, so slice indices ≥ S are unreachable.
- State encoding is a free choice. Unused encodings must go to IDLE.

## Timing
- Reset (`reset_n`=0, asynchronous, regardless of `clk`):
  - State = IDLE, so `ready`=1 and `done`=0.
  - `aeqb`=0, `mism_idx`=0, `idx`=0, `ra`=`rb`=0.
- Reset mid-CMP or in DONE aborts the operation: no `done` pulse is produced for it. The first accepting edge after `reset_n` rises starts a fresh compare.
- Let E0 be the accepting edge. Slice j is evaluated in the cycle after edge Ej.
- First mismatch at slice j: DONE is entered at edge E(j+1). `done`, `aeqb`=0 and `mism_idx`=j are all visible in that same cycle.
- All slices equal: DONE is entered at E(S). `done`=1 and `aeqb`=1 in that cycle.
- IDLE is re-entered one edge after DONE.
- Minimum start-to-start period: j+3 edges on a mismatch, S+2 edges on a full match.
- With `start` held high continuously, a new operation is accepted on every IDLE edge.
- `done` is never high for two consecutive cycles.

## Test plan
- W=8, a=b=8'hA5, 1-cycle `start` at E0 -> `done`=1 only after E4; `aeqb`=1, `mism_idx`=0; `ready`=1 after E5.
- a=8'h01, b=8'h00 -> `done` after E1 with `aeqb`=0, `mism_idx`=0. Then a=8'h80, b=8'h00 -> `done` after E4 with `mism_idx`=3.
- Start compare of a=b=8'h3C, then change a to 8'hFF and pulse `start` during CMP -> the second `start` is ignored; result `aeqb`=1; exactly one `done` pulse.
- `start` held high, alternating operands 8'h00/8'h00 and 8'h10/8'h00 -> `done` pulses spaced 6 edges (match) and 5 edges (mismatch at slice 2, `mism_idx`=2); no lost or extra pulses.
- Assert `reset_n`=0 asynchronously between edges during CMP (idx=2) -> outputs go immediately to `ready`=1, `done`=0, `aeqb`=0, `mism_idx`=0; no `done` follows. The next `start` with a=b=8'hFF gives `aeqb`=1 after E4.
- W=2 (S=1, IW=1): a=2'b10, b=2'b10 -> `done` after E1, `aeqb`=1. Then a=2'b10, b=2'b11 -> `done` after E1, `aeqb`=0, `mism_idx`=0.
